// File: rtl/serial_word_assembler_pkg.sv
// Shared constants and helpers for the serial word assembler slice.
package serial_word_assembler_pkg;

  localparam int DATA_WIDTH = 4;

  // Bit counter must be able to hold the full word length itself.
  function automatic int cnt_width(input int word_w);
    return $clog2(word_w + 1);
  endfunction

endpackage

// File: rtl/serial_word_assembler.sv
// Collects a framed serial bit stream into a WORD_W-bit word and presents it
// to a downstream parallel-load register with a valid/ready hold.
module serial_word_assembler
  import serial_word_assembler_pkg::*;
#(
  parameter int WORD_W    = DATA_WIDTH * 2,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              ser_valid,
  input  logic              ser_in,
  input  logic              ds_ready,
  output logic              load_en,
  output logic [WORD_W-1:0] d_out,
  output logic              busy,
  output logic              frame_err,
  output logic              overrun
);

  localparam int CNT_W = cnt_width(WORD_W);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    PRESENT = 2'd2
  } state_t;

  state_t              state_r;
  logic [CNT_W-1:0]    cnt_r;
  logic [WORD_W-1:0]   shift_r;
  logic [WORD_W-1:0]   d_out_r;
  logic                load_en_r;
  logic                busy_r;
  logic                frame_err_r;
  logic                overrun_r;

  logic [WORD_W-1:0]   shift_next_s;
  logic [WORD_W-1:0]   first_word_s;
  logic                cnt_last_s;

  function automatic logic [WORD_W-1:0] shift_in(input logic [WORD_W-1:0] word,
                                                 input logic              bit_in);
    if (MSB_FIRST) begin
      return {word[WORD_W-2:0], bit_in};
    end else begin
      return {bit_in, word[WORD_W-1:1]};
    end
  endfunction

  // Next shift-register values for a continuing frame and for a fresh bit 0.
  always_comb begin
    shift_next_s = shift_in(shift_r, ser_in);
    first_word_s = shift_in({WORD_W{1'b0}}, ser_in);
    cnt_last_s   = (cnt_r == CNT_W'(WORD_W - 1));
  end

  // Frame FSM with inline counter, shift register and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      cnt_r       <= {CNT_W{1'b0}};
      shift_r     <= {WORD_W{1'b0}};
      d_out_r     <= {WORD_W{1'b0}};
      load_en_r   <= 1'b0;
      busy_r      <= 1'b0;
      frame_err_r <= 1'b0;
      overrun_r   <= 1'b0;
    end else begin
      frame_err_r <= 1'b0;
      overrun_r   <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start && ser_valid) begin
            shift_r <= first_word_s;
            cnt_r   <= CNT_W'(1);
            busy_r  <= 1'b1;
            state_r <= COLLECT;
          end else begin
            state_r <= IDLE;
          end
        end
        COLLECT: begin
          if (start) begin
            // A new start always kills the partial word.
            frame_err_r <= 1'b1;
            if (ser_valid) begin
              shift_r <= first_word_s;
              cnt_r   <= CNT_W'(1);
            end else begin
              shift_r <= {WORD_W{1'b0}};
              cnt_r   <= {CNT_W{1'b0}};
              busy_r  <= 1'b0;
              state_r <= IDLE;
            end
          end else if (ser_valid) begin
            shift_r <= shift_next_s;
            if (cnt_last_s) begin
              cnt_r     <= CNT_W'(WORD_W);
              d_out_r   <= shift_next_s;
              load_en_r <= 1'b1;
              state_r   <= PRESENT;
            end else begin
              cnt_r <= cnt_r + CNT_W'(1);
            end
          end else begin
            state_r <= COLLECT;
          end
        end
        PRESENT: begin
          if (ds_ready) begin
            load_en_r <= 1'b0;
            if (start && ser_valid) begin
              shift_r <= first_word_s;
              cnt_r   <= CNT_W'(1);
              state_r <= COLLECT;
            end else begin
              cnt_r   <= {CNT_W{1'b0}};
              busy_r  <= 1'b0;
              state_r <= IDLE;
            end
          end else if (ser_valid) begin
            overrun_r <= 1'b1;
          end else begin
            state_r <= PRESENT;
          end
        end
        default: begin
          state_r   <= IDLE;
          cnt_r     <= {CNT_W{1'b0}};
          load_en_r <= 1'b0;
          busy_r    <= 1'b0;
        end
      endcase
    end
  end

  assign load_en   = load_en_r;
  assign d_out     = d_out_r;
  assign busy      = busy_r;
  assign frame_err = frame_err_r;
  assign overrun   = overrun_r;

endmodule

// File: tb/tb_serial_word_assembler.sv
// Randomized and directed bench: an MSB-first and an LSB-first instance share
// stimulus and are compared each cycle against a queue-based frame model.
module tb_serial_word_assembler;

  localparam int W = 8;

  logic clk = 1'b0;
  logic reset_n;
  logic start, ser_valid, ser_in, ds_ready;
  logic load_en_m, busy_m, frame_err_m, overrun_m;
  logic load_en_l, busy_l, frame_err_l, overrun_l;
  logic [W-1:0] d_out_m, d_out_l;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_word_assembler #(.WORD_W(W), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .reset_n(reset_n), .start(start), .ser_valid(ser_valid),
    .ser_in(ser_in), .ds_ready(ds_ready), .load_en(load_en_m), .d_out(d_out_m),
    .busy(busy_m), .frame_err(frame_err_m), .overrun(overrun_m));

  serial_word_assembler #(.WORD_W(W), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .reset_n(reset_n), .start(start), .ser_valid(ser_valid),
    .ser_in(ser_in), .ds_ready(ds_ready), .load_en(load_en_l), .d_out(d_out_l),
    .busy(busy_l), .frame_err(frame_err_l), .overrun(overrun_l));

  // Reference model: bits received so far, plus what the consumer should see.
  bit            col[$];
  bit            m_collecting, m_presenting;
  logic          m_le, m_busy, m_fe, m_ov;
  logic [W-1:0]  m_word_m, m_word_l;

  function automatic void model_reset();
    col.delete();
    m_collecting = 1'b0; m_presenting = 1'b0;
    m_le = 1'b0; m_busy = 1'b0; m_fe = 1'b0; m_ov = 1'b0;
    m_word_m = '0; m_word_l = '0;
  endfunction

  function automatic void model_update(input logic s, input logic v, input logic b, input logic r);
    m_fe = 1'b0;
    m_ov = 1'b0;
    if (m_presenting) begin
      if (r) begin
        m_presenting = 1'b0;
        m_le = 1'b0;
        if (s && v) begin col.delete(); col.push_back(b); m_collecting = 1'b1; end
      end else if (v) begin
        m_ov = 1'b1;
      end
    end else if (m_collecting) begin
      if (s) begin
        m_fe = 1'b1;
        col.delete();
        if (v) col.push_back(b);
        else m_collecting = 1'b0;
      end else if (v) begin
        col.push_back(b);
        if (col.size() == W) begin
          for (int i = 0; i < W; i++) begin
            m_word_m[W-1-i] = col[i];
            m_word_l[i]     = col[i];
          end
          col.delete();
          m_collecting = 1'b0;
          m_presenting = 1'b1;
          m_le = 1'b1;
        end
      end
    end else if (s && v) begin
      col.delete();
      col.push_back(b);
      m_collecting = 1'b1;
    end
    m_busy = m_collecting || m_presenting;
  endfunction

  function automatic logic [2*(W+4)-1:0] dut_vec();
    return {load_en_m, busy_m, frame_err_m, overrun_m, d_out_m,
            load_en_l, busy_l, frame_err_l, overrun_l, d_out_l};
  endfunction

  function automatic logic [2*(W+4)-1:0] exp_vec();
    return {m_le, m_busy, m_fe, m_ov, m_word_m, m_le, m_busy, m_fe, m_ov, m_word_l};
  endfunction

  // Drive one cycle of inputs, advance the model, and land just after the edge.
  task automatic step(input logic s, input logic v, input logic b, input logic r);
    start = s; ser_valid = v; ser_in = b; ds_ready = r;
    model_update(s, v, b, r);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    start = 1'b0; ser_valid = 1'b0; ser_in = 1'b0; ds_ready = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (dut_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL reset_state got %h want %h", dut_vec(), exp_vec());
    end
    reset_n = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_msb_frame();
    logic [W-1:0] word = 8'hA5;
    for (int i = 0; i < W; i++) begin
      step(i == 0, 1'b1, word[W-1-i], 1'b1);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL msb_frame bit%0d got %h want %h", i, dut_vec(), exp_vec());
      end
    end
    checks++;
    if (d_out_m !== 8'hA5 || load_en_m !== 1'b1) begin
      errors++;
      $display("FAIL msb_frame_word got d_out=%h load_en=%b want a5/1", d_out_m, load_en_m);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (load_en_m !== 1'b0 || dut_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL msb_frame_pulse got %h want %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_gapped_lsb();
    logic [W-1:0] word = 8'hA5;
    for (int i = 0; i < W; i++) begin
      step(i == 0, 1'b1, word[i], 1'b1);
      checks++;
      if (dut_vec() !== exp_vec() || busy_l !== 1'b1) begin
        errors++;
        $display("FAIL gapped_bit%0d got %h want %h", i, dut_vec(), exp_vec());
      end
      if (i != W - 1) begin
        for (int g = 0; g < 2; g++) begin
          step(1'b0, 1'b0, 1'($urandom_range(1)), 1'b1);
          checks++;
          if (dut_vec() !== exp_vec() || busy_l !== 1'b1) begin
            errors++;
            $display("FAIL gapped_gap%0d got %h want %h", i, dut_vec(), exp_vec());
          end
        end
      end
    end
    checks++;
    if (d_out_l !== 8'hA5 || load_en_l !== 1'b1) begin
      errors++;
      $display("FAIL gapped_word got d_out=%h load_en=%b want a5/1", d_out_l, load_en_l);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_stall_overrun();
    logic [W-1:0] word = 8'hA5;
    int ov_seen = 0;
    for (int i = 0; i < W; i++) step(i == 0, 1'b1, word[W-1-i], 1'b0);
    for (int c = 0; c < 3; c++) begin
      step(c == 1, c == 1, 1'b0, 1'b0);
      checks++;
      if (dut_vec() !== exp_vec() || d_out_m !== 8'hA5 || load_en_m !== 1'b1) begin
        errors++;
        $display("FAIL stall_cyc%0d got %h want %h", c, dut_vec(), exp_vec());
      end
      if (overrun_m) ov_seen++;
    end
    checks++;
    if (ov_seen != 1) begin
      errors++;
      $display("FAIL stall_overrun_count got %0d want 1", ov_seen);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (dut_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL stall_release got %h want %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_abort();
    logic [W-1:0] word = 8'h3C;
    int fe_seen = 0;
    for (int i = 0; i < 3; i++) step(i == 0, 1'b1, 1'($urandom_range(1)), 1'b1);
    for (int i = 0; i < W; i++) begin
      step(i == 0, 1'b1, word[W-1-i], 1'b1);
      if (frame_err_m) fe_seen++;
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL abort_bit%0d got %h want %h", i, dut_vec(), exp_vec());
      end
    end
    checks++;
    if (fe_seen != 1 || d_out_m !== 8'h3C || d_out_l !== 8'h3C) begin
      errors++;
      $display("FAIL abort_result got fe=%0d d_out=%h/%h want 1 3c/3c", fe_seen, d_out_m, d_out_l);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] w1 = 8'hA5;
    logic [W-1:0] w2 = 8'h5A;
    int rises = 0;
    logic prev = 1'b0;
    for (int i = 0; i < W; i++) step(i == 0, 1'b1, w1[W-1-i], 1'b1);
    prev = load_en_m;
    rises = 1;
    for (int i = 0; i < W + 2; i++) begin
      if (i < W) step(i == 0, 1'b1, w2[W-1-i], 1'b1);
      else step(1'b0, 1'b0, 1'b0, 1'b1);
      if (load_en_m && !prev) rises++;
      prev = load_en_m;
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL b2b_cyc%0d got %h want %h", i, dut_vec(), exp_vec());
      end
    end
    checks++;
    if (rises != 2 || d_out_m !== 8'h5A) begin
      errors++;
      $display("FAIL b2b_result got rises=%0d d_out=%h want 2 5a", rises, d_out_m);
    end
    for (int i = 0; i < 5; i++) step(i == 0, 1'b1, 1'($urandom_range(1)), 1'b1);
    #3;
    reset_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (dut_vec() !== '0) begin
      errors++;
      $display("FAIL async_reset got %h want 0", dut_vec());
    end
    #2;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'($urandom_range(1)), 1'($urandom_range(1)), 1'b1);
      checks++;
      if (dut_vec() !== exp_vec() || load_en_m !== 1'b0) begin
        errors++;
        $display("FAIL post_reset_cyc%0d got %h want %h", i, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(11) == 0, $urandom_range(9) < 7,
           1'($urandom_range(1)), $urandom_range(9) < 6);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL random_cyc%0d got %h want %h", i, dut_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_msb_frame();
    test_gapped_lsb();
    test_stall_overrun();
    test_abort();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
